ir_cache_loader: RTL and testbench

//  Instruction-side responder for ir_decoder. After reset it bulk-loads LOAD_LINES

---
 rtl/ir_cache_loader_pkg.sv | 21 ++
 rtl/ir_cache_loader_mem.sv | 41 ++++
 rtl/ir_cache_loader.sv | 166 ++++++++++++++++
 tb/tb_ir_cache_loader.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_cache_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ir_cache_loader_pkg
// Purpose : Shared defaults and loader FSM encoding for ir_cache_loader.
// Contents: DATA_WIDTH_DEF, IR_ADDR_WIDTH_DEF, LOAD_LINES_DEF, ldr_state_e
// Revision: 1.0 - initial release
// ============================================================================
package ir_cache_loader_pkg;

  localparam int DATA_WIDTH_DEF    = 8;
  localparam int IR_ADDR_WIDTH_DEF = 8;
  localparam int LOAD_LINES_DEF    = 255;

  typedef enum logic [1:0] {
    LDR_IDLE = 2'd0,
    LDR_LOAD = 2'd1,
    LDR_DONE = 2'd2
  } ldr_state_e;

endpackage
`default_nettype wire

// File: rtl/ir_cache_loader_mem.sv
`default_nettype none
// ============================================================================
// Module  : ir_cache_mem
// Purpose : Simple dual-port synchronous RAM, one write port and one read
//           port. Read data is registered and only updates when re is high,
//           so q holds its last value between reads. Contents are not reset.
// Ports   : clk            clock
//           we/waddr/wdata write port
//           re/raddr       read port (1-cycle latency)
//           q              registered read data
// Revision: 1.0 - initial release
// ============================================================================
module ir_cache_mem #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      q
);

  logic [WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
    if (re) begin
      r_q <= r_mem[raddr];
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/ir_cache_loader.sv
`default_nettype none
// ============================================================================
// Module  : ir_cache_loader
// Purpose : Bulk-loads LOAD_LINES words from a valid/ready stream into a
//           local RAM after load_start, then serves ir_decoder fetches
//           (irp in, word out one cycle later with rd_ack).
// Macro   : IR_CACHE_PARITY_EN - store ext_par alongside each word, flag
//           load parity errors (load_err) and stored-word errors (rd_perr).
//           Undefined: ext_par ignored, load_err/rd_perr tied low.
// Ports   : clk, rst_n (sync, active-low)
//           load_start                      (re)load request pulse
//           ext_valid/ext_ready/ext_data/ext_par  load stream
//           init_load_finished              cache loaded, reads served
//           rd_req/irp -> rd_ack/rd_data    fetch interface
//           load_err, rd_perr               parity status
// Revision: 1.0 - initial release
// ============================================================================
module ir_cache_loader
  import ir_cache_loader_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int IR_ADDR_WIDTH = IR_ADDR_WIDTH_DEF,
  parameter int LOAD_LINES    = LOAD_LINES_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_start,
  input  logic                     ext_valid,
  output logic                     ext_ready,
  input  logic [DATA_WIDTH-1:0]    ext_data,
  input  logic                     ext_par,
  output logic                     init_load_finished,
  input  logic                     rd_req,
  input  logic [IR_ADDR_WIDTH-1:0] irp,
  output logic                     rd_ack,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     load_err,
  output logic                     rd_perr
);

`ifdef IR_CACHE_PARITY_EN
  localparam int C_MEM_W = DATA_WIDTH + 1;
`else
  localparam int C_MEM_W = DATA_WIDTH;
`endif

  // One bit wider than irp so LOAD_LINES == 2**IR_ADDR_WIDTH is representable.
  localparam logic [IR_ADDR_WIDTH:0]   C_LINES = (IR_ADDR_WIDTH+1)'(LOAD_LINES);
  localparam logic [IR_ADDR_WIDTH-1:0] C_LAST  = IR_ADDR_WIDTH'(LOAD_LINES - 1);

  ldr_state_e               r_state;
  ldr_state_e               w_next_state;
  logic [IR_ADDR_WIDTH-1:0] r_load_cnt;
  logic                     r_ext_ready;
  logic                     r_init_done;
  logic                     r_rd_ack;
  logic                     r_rd_sel_mem;  // last ack came from RAM (else out-of-range -> 0)
  logic                     w_beat;
  logic                     w_last_beat;
  logic                     w_start;
  logic                     w_rd_accept;
  logic                     w_rd_in_range;
  logic [C_MEM_W-1:0]       w_mem_wdata;
  logic [C_MEM_W-1:0]       w_mem_q;

  assign w_beat        = ext_valid && r_ext_ready;
  assign w_last_beat   = w_beat && (r_load_cnt == C_LAST);
  // load_start is ignored while a load is in progress.
  assign w_start       = load_start && (r_state != LDR_LOAD);
  assign w_rd_accept   = rd_req && (r_state == LDR_DONE);
  assign w_rd_in_range = ({1'b0, irp} < C_LINES);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= LDR_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      LDR_IDLE: if (load_start)  w_next_state = LDR_LOAD;
      LDR_LOAD: if (w_last_beat) w_next_state = LDR_DONE;
      LDR_DONE: if (load_start)  w_next_state = LDR_LOAD;
      default:                   w_next_state = LDR_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Load counter, status flags and read handshake
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_load_cnt   <= '0;
      r_ext_ready  <= 1'b0;
      r_init_done  <= 1'b0;
      r_rd_ack     <= 1'b0;
      r_rd_sel_mem <= 1'b0;
    end else begin
      if (w_start) begin
        r_load_cnt <= '0;
      end else if (w_beat) begin
        r_load_cnt <= r_load_cnt + 1'b1;
      end
      r_ext_ready <= (w_next_state == LDR_LOAD);
      r_init_done <= (w_next_state == LDR_DONE);
      r_rd_ack    <= w_rd_accept;
      if (w_rd_accept) begin
        r_rd_sel_mem <= w_rd_in_range;
      end
    end
  end

`ifdef IR_CACHE_PARITY_EN
  logic r_load_err;

  assign w_mem_wdata = {ext_par, ext_data};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_load_err <= 1'b0;
    end else if (w_start) begin
      r_load_err <= 1'b0;
    end else if (w_beat && (^{ext_data, ext_par})) begin
      r_load_err <= 1'b1;
    end
  end

  assign load_err = r_load_err;
  assign rd_perr  = r_rd_ack && r_rd_sel_mem && (^w_mem_q);
`else
  logic w_unused_par;

  assign w_mem_wdata  = ext_data;
  assign w_unused_par = ext_par;
  assign load_err     = 1'b0;
  assign rd_perr      = 1'b0;
`endif

  // RAM read port only fires for in-range fetches, so its output register
  // doubles as the rd_data hold register between acks.
  ir_cache_mem #(
    .WIDTH      (C_MEM_W),
    .ADDR_WIDTH (IR_ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (w_beat),
    .waddr (r_load_cnt),
    .wdata (w_mem_wdata),
    .re    (w_rd_accept && w_rd_in_range),
    .raddr (irp),
    .q     (w_mem_q)
  );

  assign ext_ready          = r_ext_ready;
  assign init_load_finished = r_init_done;
  assign rd_ack             = r_rd_ack;
  assign rd_data            = r_rd_sel_mem ? w_mem_q[DATA_WIDTH-1:0] : '0;

endmodule
`default_nettype wire

// File: tb/tb_ir_cache_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_ir_cache_loader
// Purpose : Directed self-checking bench for ir_cache_loader (8-bit words,
//           8-bit irp, 255 lines). Parity expectations follow
//           IR_CACHE_PARITY_EN when it is defined for the build.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ir_cache_loader;

`ifdef IR_CACHE_PARITY_EN
  localparam bit C_PAR = 1'b1;
`else
  localparam bit C_PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_start;
  logic       ext_valid;
  logic       ext_ready;
  logic [7:0] ext_data;
  logic       ext_par;
  logic       init_load_finished;
  logic       rd_req;
  logic [7:0] irp;
  logic       rd_ack;
  logic [7:0] rd_data;
  logic       load_err;
  logic       rd_perr;

  int n_vec = 0;
  int n_err = 0;
  int beats;
  bit ack_seen;

  always #5 clk = ~clk;

  ir_cache_loader #(
    .DATA_WIDTH    (8),
    .IR_ADDR_WIDTH (8),
    .LOAD_LINES    (255)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .load_start         (load_start),
    .ext_valid          (ext_valid),
    .ext_ready          (ext_ready),
    .ext_data           (ext_data),
    .ext_par            (ext_par),
    .init_load_finished (init_load_finished),
    .rd_req             (rd_req),
    .irp                (irp),
    .rd_ack             (rd_ack),
    .rd_data            (rd_data),
    .load_err           (load_err),
    .rd_perr            (rd_perr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pat(input int mode, input int a);
    logic [7:0] av;
    av = a[7:0];
    case (mode)
      0:       return av;
      1:       return ~av;
      2:       return 8'hA5;
      default: return av ^ 8'h3C;
    endcase
  endfunction

  // Streams nbeats words (index base+n), optionally toggling valid. bad selects
  // a beat index whose ext_par is inverted (-1 for none).
  task automatic do_load(input int mode, input bit toggle, input int base, input int nbeats,
                         input int bad, output int nb, output bit acks);
    logic v;
    bit   acc;
    int   cyc;
    nb   = 0;
    cyc  = 0;
    acks = 1'b0;
    while (nb < nbeats && cyc < 2000) begin
      v         = toggle ? (cyc % 2 == 0) : 1'b1;
      ext_valid = v;
      ext_data  = v ? pat(mode, base + nb) : 8'hEE;
      ext_par   = (^ext_data) ^ ((base + nb) == bad);
      acc       = v && ext_ready;
      tick();
      if (rd_ack) acks = 1'b1;
      if (acc) nb++;
      cyc++;
    end
    ext_valid = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input bit exp_perr, input string tag);
    rd_req = 1'b1;
    irp    = a;
    tick();
    rd_req = 1'b0;
    chk({tag, " ack"},  rd_ack,  1);
    chk({tag, " data"}, rd_data, exp);
    chk({tag, " perr"}, rd_perr, exp_perr);
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; load_start = 1'b0; ext_valid = 1'b0; ext_data = '0;
    ext_par = 1'b0; rd_req = 1'b0; irp = '0;
    tick(); tick();

    // Reset values
    chk("rst ext_ready", ext_ready, 0);
    chk("rst init", init_load_finished, 0);
    chk("rst rd_ack", rd_ack, 0);
    chk("rst rd_data", rd_data, 0);
    chk("rst load_err", load_err, 0);
    chk("rst rd_perr", rd_perr, 0);

    rst_n = 1'b1;
    rd_req = 1'b1; irp = 8'h00;
    tick();
    rd_req = 1'b0;
    chk("idle no ack", rd_ack, 0);

    // 1. Full load, data = addr
    pulse_start();
    chk("t1 ready in load", ext_ready, 1);
    chk("t1 init low", init_load_finished, 0);
    do_load(0, 1'b0, 0, 255, -1, beats, ack_seen);
    chk("t1 beats", beats, 255);
    chk("t1 ready low after last", ext_ready, 0);
    chk("t1 init high", init_load_finished, 1);

    // 2. Single, back-to-back, out-of-range, hold
    rd(8'h10, 8'h10, 1'b0, "t2 irp10");
    rd_req = 1'b1; irp = 8'h00;
    tick();
    irp = 8'h01;
    chk("t2 b2b0 ack", rd_ack, 1); chk("t2 b2b0 data", rd_data, 8'h00);
    tick();
    irp = 8'h02;
    chk("t2 b2b1 ack", rd_ack, 1); chk("t2 b2b1 data", rd_data, 8'h01);
    tick();
    rd_req = 1'b0;
    chk("t2 b2b2 ack", rd_ack, 1); chk("t2 b2b2 data", rd_data, 8'h02);
    rd(8'hFF, 8'h00, 1'b0, "t2 oob");
    rd(8'hFE, 8'hFE, 1'b0, "t2 top");
    rd(8'h10, 8'h10, 1'b0, "t2 irp10b");
    tick();
    chk("t2 hold ack", rd_ack, 0);
    chk("t2 hold data", rd_data, 8'h10);

    // 3. Toggling valid, reads ignored during load
    pulse_start();
    rd_req = 1'b1; irp = 8'h07;
    do_load(3, 1'b1, 0, 255, -1, beats, ack_seen);
    rd_req = 1'b0;
    chk("t3 beats", beats, 255);
    chk("t3 no ack in load", ack_seen, 0);
    chk("t3 data held", rd_data, 8'h10);
    chk("t3 init high", init_load_finished, 1);
    rd(8'h00, 8'h3C, 1'b0, "t3 irp00");
    rd(8'h7F, 8'h43, 1'b0, "t3 irp7f");
    rd(8'hFE, 8'hC2, 1'b0, "t3 irpfe");

    // 4. Reset mid-load, then reload with ~addr
    pulse_start();
    do_load(2, 1'b0, 0, 100, -1, beats, ack_seen);
    chk("t4 partial beats", beats, 100);
    chk("t4 still loading", ext_ready, 1);
    rst_n = 1'b0;
    tick();
    chk("t4 rst ready", ext_ready, 0);
    chk("t4 rst init", init_load_finished, 0);
    chk("t4 rst data", rd_data, 0);
    rst_n = 1'b1; ext_valid = 1'b1;
    tick(); tick();
    ext_valid = 1'b0;
    chk("t4 idle stays", ext_ready, 0);
    pulse_start();
    do_load(1, 1'b0, 0, 255, -1, beats, ack_seen);
    chk("t4 beats", beats, 255);
    rd(8'h05, 8'hFA, 1'b0, "t4 irp05");
    rd(8'h40, 8'hBF, 1'b0, "t4 irp40");
    rd(8'hFE, 8'h01, 1'b0, "t4 irpfe");

    // 5. Reload from DONE with a read in the same cycle; start in LOAD ignored
    load_start = 1'b1; rd_req = 1'b1; irp = 8'h05;
    tick();
    load_start = 1'b0; rd_req = 1'b0;
    chk("t5 same-cycle ack", rd_ack, 1);
    chk("t5 same-cycle data", rd_data, 8'hFA);
    chk("t5 init dropped", init_load_finished, 0);
    chk("t5 ready", ext_ready, 1);
    do_load(2, 1'b0, 0, 50, -1, beats, ack_seen);
    pulse_start();
    do_load(2, 1'b0, 50, 205, -1, beats, ack_seen);
    chk("t5 beats", beats, 205);
    chk("t5 init high", init_load_finished, 1);
    for (int a = 0; a < 255; a++) begin
      rd(a[7:0], 8'hA5, 1'b0, "t5 a5");
    end

    // 6. Parity fault on beat 3
    pulse_start();
    do_load(0, 1'b0, 0, 255, 3, beats, ack_seen);
    chk("t6 beats", beats, 255);
    chk("t6 load_err", load_err, C_PAR);
    rd(8'h03, 8'h03, C_PAR, "t6 irp03");
    rd(8'h04, 8'h04, 1'b0, "t6 irp04");
    pulse_start();
    chk("t6 load_err cleared", load_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
